gray2bin_arb: RTL and testbench

GRAY2BIN_ARB -- requirements
Module: gray2bin_arb

---
 rtl/gray2bin_arb_pkg.sv | 14 +
 rtl/gray2bin_arb_gray2bin.sv | 66 ++++++
 rtl/gray2bin_arb_rr_arb.sv | 32 +++
 rtl/gray2bin_arb.sv | 101 ++++++++++
 tb/tb_gray2bin_arb.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/gray2bin_arb_pkg.sv
// Shared types for the round-robin Gray-to-binary converter front end.
package gray2bin_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gray2bin_arb_gray2bin.sv
// Gray-to-binary converter; speed picks serial, Brent-Kung or Sklansky XOR prefix.
module gray2bin #(
  parameter int width = 8,
  parameter int speed = 2
) (
  input  logic [width-1:0] gray_i,
  output logic [width-1:0] bin_o
);

  function automatic logic [width-1:0] conv_serial(input logic [width-1:0] g);
    logic [width-1:0] b;
    b = {width{1'b0}};
    b[width-1] = g[width-1];
    for (int k = width - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Prefix networks run on the bit-reversed word so index 0 is the MSB.
  function automatic logic [width-1:0] conv_brent_kung(input logic [width-1:0] g);
    logic [width-1:0] p;
    logic [width-1:0] b;
    int top;
    for (int j = 0; j < width; j++) p[j] = g[width-1-j];
    top = 1;
    while (top * 2 < width) top = top * 2;
    for (int d = 1; d < width; d = d * 2) begin
      for (int j = 0; j < width; j++) begin
        p[j] = (((j + 1) % (2 * d)) == 0) ? (p[j] ^ p[j-d]) : p[j];
      end
    end
    for (int d = top / 2; d >= 1; d = d / 2) begin
      for (int j = 0; j < width; j++) begin
        p[j] = ((((j + 1) % (2 * d)) == d) && (j > d)) ? (p[j] ^ p[j-d]) : p[j];
      end
    end
    for (int j = 0; j < width; j++) b[width-1-j] = p[j];
    return b;
  endfunction

  function automatic logic [width-1:0] conv_sklansky(input logic [width-1:0] g);
    logic [width-1:0] p;
    logic [width-1:0] q;
    logic [width-1:0] b;
    for (int j = 0; j < width; j++) p[j] = g[width-1-j];
    for (int d = 1; d < width; d = d * 2) begin
      q = p;
      for (int j = 0; j < width; j++) begin
        q[j] = ((j & d) != 0) ? (p[j] ^ p[(j / d) * d - 1]) : p[j];
      end
      p = q;
    end
    for (int j = 0; j < width; j++) b[width-1-j] = p[j];
    return b;
  endfunction

  if (speed == 0) begin : g_serial
    assign bin_o = conv_serial(gray_i);
  end else if (speed == 1) begin : g_brent_kung
    assign bin_o = conv_brent_kung(gray_i);
  end else begin : g_sklansky
    assign bin_o = conv_sklansky(gray_i);
  end

endmodule

// File: rtl/gray2bin_arb_rr_arb.sv
// Round-robin arbiter: first asserted request at or above the pointer, wrapping.
module rr_arb #(
  parameter int NumReq = 4,
  parameter int IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  int   cand_s;
  logic take_s;

  // walk upward from the pointer; the first hit wins and blocks the rest
  always_comb begin
    gnt_o  = {NumReq{1'b0}};
    idx_o  = {IdxW{1'b0}};
    any_o  = 1'b0;
    cand_s = 0;
    take_s = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      cand_s        = (int'(ptr_i) + k) % NumReq;
      take_s        = req_i[cand_s] & ~any_o;
      gnt_o[cand_s] = take_s;
      idx_o         = take_s ? IdxW'(cand_s) : idx_o;
      any_o         = any_o | take_s;
    end
  end

endmodule

// File: rtl/gray2bin_arb.sv
// One shared Gray-to-binary converter serving NumReq requesters round-robin,
// one conversion in flight: grant -> CONV (one cycle) -> HOLD until consumed.
module gray2bin_arb
  import gray2bin_arb_pkg::*;
#(
  parameter int  width  = 8,
  parameter int  speed  = 2,
  parameter int  NumReq = 4,
  localparam int IdxW   = idx_width(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq*width-1:0] req_gray_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [width-1:0]        out_bin_o,
  output logic [IdxW-1:0]         out_id_o
);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d, gid_q, out_id_q, arb_idx_s;
  logic [width-1:0]  gray_q, gray_sel_s, conv_bin_s, out_bin_q;
  logic [NumReq-1:0] arb_gnt_s;
  logic              arb_any_s, can_grant_s, grant_s, out_valid_q;

  rr_arb #(.NumReq(NumReq), .IdxW(IdxW)) u_rr_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .any_o (arb_any_s)
  );

  gray2bin #(.width(width), .speed(speed)) u_gray2bin (
    .gray_i (gray_q),
    .bin_o  (conv_bin_s)
  );

  // grant window is IDLE, or HOLD while the consumer takes the current result
  always_comb begin
    can_grant_s = (state_q == IDLE) || ((state_q == HOLD) && out_ready_i);
    grant_s     = can_grant_s && arb_any_s;
    gray_sel_s  = {width{1'b0}};
    for (int i = 0; i < NumReq; i++) begin
      gray_sel_s = arb_gnt_s[i] ? req_gray_i[i*width +: width] : gray_sel_s;
    end
    if (grant_s) begin
      ptr_d = (arb_idx_s == IdxW'(NumReq - 1)) ? {IdxW{1'b0}} : (arb_idx_s + IdxW'(1));
    end else begin
      ptr_d = ptr_q;
    end
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant_s ? CONV : IDLE;
      CONV:    state_d = HOLD;
      HOLD:    state_d = out_ready_i ? (grant_s ? CONV : IDLE) : HOLD;
      default: state_d = IDLE;
    endcase
  end

  // ready is forced low while reset is held since the FSM already reads IDLE
  always_comb begin
    if (rst_ni && grant_s) begin
      req_ready_o = arb_gnt_s;
    end else begin
      req_ready_o = {NumReq{1'b0}};
    end
  end

  // state, pointer and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= {IdxW{1'b0}};
      gray_q      <= {width{1'b0}};
      gid_q       <= {IdxW{1'b0}};
      out_bin_q   <= {width{1'b0}};
      out_id_q    <= {IdxW{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= (state_d == HOLD);
      if (grant_s) begin
        gray_q <= gray_sel_s;
        gid_q  <= arb_idx_s;
      end
      if (state_q == CONV) begin
        out_bin_q <= conv_bin_s;
        out_id_q  <= gid_q;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_bin_o   = out_bin_q;
  assign out_id_o    = out_id_q;

endmodule

// File: tb/tb_gray2bin_arb.sv
// Directed and random stimulus for gray2bin_arb against a transaction-level model.
module tb_gray2bin_arb;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_gray = '0;
  logic           out_ready = 1'b0;

  logic [N-1:0] rdy2, rdy1, rdy0;
  logic         ov2, ov1, ov0;
  logic [W-1:0] bin2, bin1, bin0;
  logic [1:0]   id2, id1, id0;

  int checks = 0;
  int failures = 0;

  // model: one result converting, one presented, pointer
  logic         m_conv = 1'b0;
  logic         m_hold = 1'b0;
  int           m_ptr = 0;
  logic [W-1:0] p_bin = '0, m_bin = '0;
  int           p_id = 0, m_id = 0;

  always #5 clk = ~clk;

  gray2bin_arb #(.width(W), .speed(2), .NumReq(N)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_gray_i(req_gray),
    .req_ready_o(rdy2), .out_valid_o(ov2), .out_ready_i(out_ready),
    .out_bin_o(bin2), .out_id_o(id2));

  gray2bin_arb #(.width(W), .speed(1), .NumReq(N)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_gray_i(req_gray),
    .req_ready_o(rdy1), .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_bin_o(bin1), .out_id_o(id1));

  gray2bin_arb #(.width(W), .speed(0), .NumReq(N)) u_s0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_gray_i(req_gray),
    .req_ready_o(rdy0), .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_bin_o(bin0), .out_id_o(id0));

  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int k = 1; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: check registered outputs, drive inputs, check ready, advance model
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] g, input logic rdy,
                      output logic [N-1:0] rdy_obs);
    logic [N-1:0] exp_rdy;
    logic         ok;
    int           gi;
    int           c;
    chk("out_valid", {31'd0, ov2}, {31'd0, m_hold});
    if (m_hold) begin
      chk("out_bin_s2", {24'd0, bin2}, {24'd0, m_bin});
      chk("out_bin_s1", {24'd0, bin1}, {24'd0, m_bin});
      chk("out_bin_s0", {24'd0, bin0}, {24'd0, m_bin});
      chk("out_id", {30'd0, id2}, 32'(m_id));
    end
    req_valid = v;
    req_gray  = g;
    out_ready = rdy;
    #1;
    ok = (!m_conv && !m_hold) || (m_hold && rdy);
    gi = -1;
    if (ok) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (gi < 0 && v[c]) gi = c;
      end
    end
    exp_rdy = '0;
    if (gi >= 0) exp_rdy[gi] = 1'b1;
    chk("req_ready", {28'd0, rdy2}, {28'd0, exp_rdy});
    rdy_obs = rdy2;
    if (m_conv) begin
      m_hold = 1'b1;
      m_bin  = p_bin;
      m_id   = p_id;
      m_conv = 1'b0;
    end else if (m_hold && rdy) begin
      m_hold = 1'b0;
    end
    if (gi >= 0) begin
      m_conv = 1'b1;
      p_bin  = ref_bin(g[gi*W +: W]);
      p_id   = gi;
      m_ptr  = (gi + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_out_valid", {31'd0, ov2}, 32'd0);
    chk("rst_out_bin", {24'd0, bin2}, 32'd0);
    chk("rst_out_id", {30'd0, id2}, 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_conv = 1'b0;
    m_hold = 1'b0;
    m_ptr  = 0;
  endtask

  initial begin
    logic [N-1:0]   obs;
    logic [N-1:0]   rv;
    logic [N*W-1:0] rg;
    int             order[5];
    order = '{0, 1, 2, 3, 0};

    // reset with all requests raised: nothing may be accepted
    #2;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    @(posedge clk);
    #1;
    chk("rst_req_ready", {28'd0, rdy2}, 32'd0);
    chk("rst_valid0", {31'd0, ov2}, 32'd0);
    chk("rst_bin0", {24'd0, bin2}, 32'd0);
    chk("rst_id0", {30'd0, id2}, 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // requester 2 sends 0xC6
    step(4'b0100, 32'h00C6_0000, 1'b1, obs);
    chk("c6_grant", {28'd0, obs}, 32'b0100);
    step(4'b0000, 32'h0, 1'b1, obs);
    chk("c6_valid", {31'd0, ov2}, 32'd1);
    chk("c6_bin", {24'd0, bin2}, 32'h84);
    chk("c6_id", {30'd0, id2}, 32'd2);
    step(4'b0000, 32'h0, 1'b1, obs);

    // all four requesting after reset: 0,1,2,3,0, one grant per two cycles
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 32'($urandom()), 1'b1, obs);
      chk("rr_order", {28'd0, obs}, 32'(1 << order[k]));
      step(4'b1111, 32'($urandom()), 1'b1, obs);
      chk("rr_gap", {28'd0, obs}, 32'd0);
    end
    step(4'b0000, 32'h0, 1'b1, obs);

    // requester 1 sends 0x80, consumer stalls five cycles
    step(4'b0010, 32'h0000_8000, 1'b0, obs);
    chk("stall_grant", {28'd0, obs}, 32'b0010);
    step(4'b0001, 32'($urandom()), 1'b0, obs);
    for (int k = 0; k < 5; k++) begin
      chk("stall_bin", {24'd0, bin2}, 32'hFF);
      chk("stall_id", {30'd0, id2}, 32'd1);
      step(4'b0001, 32'($urandom()), 1'b0, obs);
      chk("stall_no_ready", {28'd0, obs}, 32'd0);
    end
    step(4'b0001, 32'($urandom()), 1'b1, obs);
    chk("stall_release_grant", {28'd0, obs}, 32'b0001);
    step(4'b0000, 32'h0, 1'b1, obs);
    step(4'b0000, 32'h0, 1'b1, obs);

    // reset while converting discards the result
    step(4'b0001, 32'($urandom()), 1'b1, obs);
    do_reset();
    step(4'b0000, 32'h0, 1'b1, obs);
    chk("post_rst_valid", {31'd0, ov2}, 32'd0);
    step(4'b1000, 32'($urandom()), 1'b1, obs);
    chk("req3_grant", {28'd0, obs}, 32'b1000);
    step(4'b0000, 32'h0, 1'b1, obs);
    chk("req3_id", {30'd0, id2}, 32'd3);
    step(4'b0000, 32'h0, 1'b1, obs);

    // random traffic with random backpressure
    for (int k = 0; k < 300; k++) begin
      rv = 4'($urandom_range(0, 15));
      rg = 32'($urandom());
      step(rv, rg, ($urandom_range(0, 3) != 0), obs);
    end

    // exhaustive sweep through all three converter variants
    do_reset();
    for (int g = 0; g < 256; g++) begin
      step(4'b0001, 32'(g), 1'b1, obs);
      step(4'b0000, 32'h0, 1'b1, obs);
      if (g == 0) chk("sweep_zero", {24'd0, bin2}, 32'd0);
    end
    step(4'b0000, 32'h0, 1'b1, obs);
    step(4'b0000, 32'h0, 1'b1, obs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
